bids22_host: RTL and testbench
==============================

# bids22_host

Controller-side sequencer that drives the auction engine's C_ command port. It accepts one round configuration over a valid/ready handshake, programs the engine with the Unlock → Load → Mask → Timer → BidCharge → Lock opcode sequence, holds C_start for the requested round length, waits for roundOver and returns the result. It sits between the system host (CPU or bench) and the auction engine, as the initiator of the protocol the engine responds to.

## Interface
- UNLOCK_KEY, 32'h0F0F0F0F, data word sent with Unlock and Lock.
- DRAIN_MAX, 1024, maximum cycles to wait for roundOver after C_start drops.
- clk  in  1  clock, all logic on posedge.
- reset_n  in  1  reset; one clock, asynchronous, active-low.
- cfg_valid  in  1  round request valid.
- cfg_ready  out  1  request accepted when cfg_valid && cfg_ready.
- cfg_xval / cfg_yval / cfg_zval  in  32 each  initial balances for X, Y and Z.
- cfg_mask  in  3  bidder enable mask, {X,Y,Z}.
- cfg_timer  in  32  engine timer value.
- cfg_cost  in  32  per-bid charge.
- cfg_round_len  in  16  cycles C_start is held; 0 is treated as 1.
- C_data  out  32  command data to engine.
- C_op  out  4  opcode to engine.
- C_start  out  1  round active.
- ready  in  1  engine ready.
- err  in  2  engine error, registered by engine.
- roundOver  in  1  engine round complete.
- maxBid  in  32  engine winning amount.
- X_win / Y_win / Z_win  in  1 each  engine winner flags.
- res_valid  out  1  one-cycle result strobe.
- res_maxBid  out  32  captured maxBid.
- res_winner  out  2  winner code: 0 none, 1 X, 2 Y, 3 Z.
- res_err  out  2  first illegal engine error; 0 if none.
- res_timeout  out  1  roundOver not seen within DRAIN_MAX.

## Operation
- **State sequence:** IDLE → WAITRDY → UNLOCK → LOADX → LOADY → LOADZ → MASK → TIMER → COST → LOCK → CHECK → RUN → DRAIN → REPORT → IDLE.
- **IDLE:**
  - cfg_ready = 1 in IDLE only.
  - On handshake, all cfg_* fields are registered. Later input changes have no effect.
- **WAITRDY:** stays until ready = 1.
- **Command states:** each drives its opcode for exactly one cycle, back to back.
  - UNLOCK: op 1, data UNLOCK_KEY.
  - LOADX: op 3, data xval.
  - LOADY: op 4, data yval.
  - LOADZ: op 5, data zval.
  - MASK: op 6, data {29'b0, mask}.
  - TIMER: op 7, data timer.
  - COST: op 8, data cost.
  - LOCK: op 2, data UNLOCK_KEY.
- **CHECK:** drives NoOp (0) with C_data = 0.
- **err sampling:**
  - err is sampled in every cycle from LOADX through CHECK; each sample is the response to the previous cycle's op.
  - err = 2'b10 seen in the LOADX cycle (response to UNLOCK, "already unlocked") is ignored.
  - Any other nonzero err latches res_err (first one wins). The FSM then goes directly to REPORT; C_start is never asserted.
- **RUN:** C_op = 0, C_start = 1 for max(round_len, 1) cycles.
- **DRAIN:** C_start = 0; wait for roundOver.
  - On roundOver = 1: capture maxBid, and capture winner with priority X > Y > Z. Go to REPORT.
  - If DRAIN_MAX cycles pass without roundOver: set res_timeout, res_winner = 0, res_maxBid = 0. Go to REPORT.
- **REPORT:** res_valid = 1 for one cycle. res_* hold their values until the next accepted request clears them.

## Timing
- All outputs are registered.
- Reset values: C_op = 0, C_data = 0, C_start = 0, cfg_ready = 0, res_valid = 0, res_maxBid = 0, res_winner = 0, res_err = 0, res_timeout = 0.
- cfg_ready rises in the first cycle after reset_n deasserts.
- Handshake at edge t:
  - WAITRDY occupies cycle t+1.
  - With ready = 1, the eight ops occupy cycles t+2 .. t+9 and CHECK occupies t+10.
  - RUN starts at t+11.
- C_start and C_op are never nonzero in the same cycle.
- roundOver arriving while in RUN is ignored; only DRAIN samples it.
- The DRAIN counter is 32-bit, saturating. A timeout fires in the cycle the count equals DRAIN_MAX.
- Reset asserted mid-sequence: outputs return to reset values asynchronously and the FSM goes to IDLE. There is no partial-lock recovery; the engine is reprogrammed on the next request.

## Structure
- bids22_pkg holds:
  - op_e: NoOp 0, Unlock 1, Lock 2, LoadX 3, LoadY 4, LoadZ 5, SetXYZmask 6, SetTimer 7, BidCharge 8.
  - winner_e: none, X, Y, Z.
  - host_state_e.
- No sub-module. The block is one FSM plus a shared 32-bit counter, reused for the RUN and DRAIN phases.

## Test plan
- **Nominal round:** xval = 100, yval = 200, zval = 300, mask = 3'b111, cost = 1, round_len = 5; engine ready.
  - Op sequence 1, 3, 4, 5, 6, 7, 8, 2 appears on consecutive cycles t+2..t+9.
  - C_start is high for exactly 5 cycles.
- **Winner capture:** roundOver with Y_win = 1 and maxBid = 42 → res_valid pulse, res_winner = 2, res_maxBid = 42, res_err = 0.
- **Config error:** engine returns err = 2'b11 after LOADY → res_err = 2'b11, C_start never asserted, res_valid 1 cycle later.
- **Timeout:** DRAIN_MAX = 8, roundOver held low → res_timeout = 1 exactly 8 cycles after C_start falls, res_winner = 0.
- **Mid-sequence reset:** reset_n pulsed low during MASK → C_op = 0 and cfg_ready = 0 immediately; cfg_ready = 1 the cycle after release; a new request runs a full sequence.
- **Zero round length and blocked handshake:** round_len = 0 → C_start high for 1 cycle; cfg_valid held high throughout → only one request accepted per sequence.

Source files
------------

// File: rtl/bids22_pkg.sv
// bids22_pkg: opcodes, winner codes, host states and constants shared by the
// auction-engine host sequencer.
package bids22_pkg;

    localparam logic [31:0] UNLOCK_KEY = 32'h0F0F0F0F;
    localparam int          DRAIN_MAX  = 1024;

    typedef enum logic [3:0] {
        NoOp       = 4'd0,
        Unlock     = 4'd1,
        Lock       = 4'd2,
        LoadX      = 4'd3,
        LoadY      = 4'd4,
        LoadZ      = 4'd5,
        SetXYZmask = 4'd6,
        SetTimer   = 4'd7,
        BidCharge  = 4'd8
    } op_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_X    = 2'd1,
        WIN_Y    = 2'd2,
        WIN_Z    = 2'd3
    } winner_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WAITRDY,
        S_UNLOCK,
        S_LOADX,
        S_LOADY,
        S_LOADZ,
        S_MASK,
        S_TIMER,
        S_COST,
        S_LOCK,
        S_CHECK,
        S_RUN,
        S_DRAIN,
        S_REPORT
    } host_state_e;

    // Several engine flags may be set at once; X outranks Y outranks Z.
    function automatic winner_e pick_winner(input logic x, input logic y, input logic z);
        return x ? WIN_X : y ? WIN_Y : z ? WIN_Z : WIN_NONE;
    endfunction

endpackage

// File: rtl/bids22_host.sv
// bids22_host: accepts one round request, programs the auction engine with the
// unlock/load/lock command sequence, runs the round and reports the result.
module bids22_host
    import bids22_pkg::*;
#(
    parameter int DRAIN_MAX = bids22_pkg::DRAIN_MAX
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [31:0] cfg_xval,
    input  logic [31:0] cfg_yval,
    input  logic [31:0] cfg_zval,
    input  logic [2:0]  cfg_mask,
    input  logic [31:0] cfg_timer,
    input  logic [31:0] cfg_cost,
    input  logic [15:0] cfg_round_len,
    output logic [31:0] C_data,
    output logic [3:0]  C_op,
    output logic        C_start,
    input  logic        ready,
    input  logic [1:0]  err,
    input  logic        roundOver,
    input  logic [31:0] maxBid,
    input  logic        X_win,
    input  logic        Y_win,
    input  logic        Z_win,
    output logic        res_valid,
    output logic [31:0] res_maxBid,
    output logic [1:0]  res_winner,
    output logic [1:0]  res_err,
    output logic        res_timeout
);

    localparam logic [31:0] DRAIN_LIM = 32'(DRAIN_MAX);

    host_state_e state;
    logic [31:0] cnt;
    logic [31:0] xval, yval, zval, timer, cost;
    logic [2:0]  mask;
    logic [15:0] round_len;
    logic [31:0] run_len;
    logic        err_hit;

    assign run_len = (round_len == 16'd0) ? 32'd1 : {16'd0, round_len};
    // "Already unlocked" is the only tolerated engine complaint, and only as the Unlock response.
    assign err_hit = (state >= S_LOADX) && (state <= S_CHECK) && (err != 2'b00)
                   && !((state == S_LOADX) && (err == 2'b10));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            cnt         <= 32'd0;
            cfg_ready   <= 1'b0;
            C_op        <= NoOp;
            C_data      <= 32'd0;
            C_start     <= 1'b0;
            res_valid   <= 1'b0;
            res_maxBid  <= 32'd0;
            res_winner  <= WIN_NONE;
            res_err     <= 2'b00;
            res_timeout <= 1'b0;
            xval        <= 32'd0;
            yval        <= 32'd0;
            zval        <= 32'd0;
            timer       <= 32'd0;
            cost        <= 32'd0;
            mask        <= 3'd0;
            round_len   <= 16'd0;
        end else begin
            res_valid <= 1'b0;
            if (err_hit) begin
                res_err   <= err;
                res_valid <= 1'b1;
                C_op      <= NoOp;
                C_data    <= 32'd0;
                state     <= S_REPORT;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (cfg_valid && cfg_ready) begin
                            xval        <= cfg_xval;
                            yval        <= cfg_yval;
                            zval        <= cfg_zval;
                            mask        <= cfg_mask;
                            timer       <= cfg_timer;
                            cost        <= cfg_cost;
                            round_len   <= cfg_round_len;
                            res_maxBid  <= 32'd0;
                            res_winner  <= WIN_NONE;
                            res_err     <= 2'b00;
                            res_timeout <= 1'b0;
                            cfg_ready   <= 1'b0;
                            state       <= S_WAITRDY;
                        end else begin
                            cfg_ready <= 1'b1;
                        end
                    end
                    S_WAITRDY: begin
                        if (ready) begin
                            C_op   <= Unlock;
                            C_data <= UNLOCK_KEY;
                            state  <= S_UNLOCK;
                        end
                    end
                    S_UNLOCK: begin C_op <= LoadX;      C_data <= xval;           state <= S_LOADX; end
                    S_LOADX:  begin C_op <= LoadY;      C_data <= yval;           state <= S_LOADY; end
                    S_LOADY:  begin C_op <= LoadZ;      C_data <= zval;           state <= S_LOADZ; end
                    S_LOADZ:  begin C_op <= SetXYZmask; C_data <= {29'd0, mask};  state <= S_MASK;  end
                    S_MASK:   begin C_op <= SetTimer;   C_data <= timer;          state <= S_TIMER; end
                    S_TIMER:  begin C_op <= BidCharge;  C_data <= cost;           state <= S_COST;  end
                    S_COST:   begin C_op <= Lock;       C_data <= UNLOCK_KEY;     state <= S_LOCK;  end
                    S_LOCK:   begin C_op <= NoOp;       C_data <= 32'd0;          state <= S_CHECK; end
                    S_CHECK: begin
                        C_start <= 1'b1;
                        cnt     <= 32'd1;
                        state   <= S_RUN;
                    end
                    S_RUN: begin
                        if (cnt >= run_len) begin
                            C_start <= 1'b0;
                            cnt     <= 32'd1;
                            state   <= S_DRAIN;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    S_DRAIN: begin
                        if (roundOver) begin
                            res_maxBid <= maxBid;
                            res_winner <= pick_winner(X_win, Y_win, Z_win);
                            res_valid  <= 1'b1;
                            state      <= S_REPORT;
                        end else if (cnt == DRAIN_LIM) begin
                            res_timeout <= 1'b1;
                            res_winner  <= WIN_NONE;
                            res_maxBid  <= 32'd0;
                            res_valid   <= 1'b1;
                            state       <= S_REPORT;
                        end else if (cnt != 32'hFFFF_FFFF) begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    S_REPORT: begin
                        cfg_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bids22_host.sv
// tb_bids22_host: directed rounds against a small engine stub; expectations are
// queued at request time and popped by monitors as the host produces output.
module tb_bids22_host;
    import bids22_pkg::*;

    localparam int DMAX = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_valid, cfg_ready;
    logic [31:0] cfg_xval, cfg_yval, cfg_zval, cfg_timer, cfg_cost;
    logic [2:0]  cfg_mask;
    logic [15:0] cfg_round_len;
    logic [31:0] C_data;
    logic [3:0]  C_op;
    logic        C_start;
    logic        ready;
    logic [1:0]  err;
    logic        roundOver;
    logic [31:0] maxBid;
    logic        X_win, Y_win, Z_win;
    logic        res_valid;
    logic [31:0] res_maxBid;
    logic [1:0]  res_winner, res_err;
    logic        res_timeout;

    always #5 clk = ~clk;

    bids22_host #(.DRAIN_MAX(DMAX)) dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_xval(cfg_xval), .cfg_yval(cfg_yval), .cfg_zval(cfg_zval),
        .cfg_mask(cfg_mask), .cfg_timer(cfg_timer), .cfg_cost(cfg_cost),
        .cfg_round_len(cfg_round_len),
        .C_data(C_data), .C_op(C_op), .C_start(C_start),
        .ready(ready), .err(err), .roundOver(roundOver), .maxBid(maxBid),
        .X_win(X_win), .Y_win(Y_win), .Z_win(Z_win),
        .res_valid(res_valid), .res_maxBid(res_maxBid), .res_winner(res_winner),
        .res_err(res_err), .res_timeout(res_timeout)
    );

    typedef struct { int cyc; logic [3:0] op; logic [31:0] data; } op_t;
    typedef struct { int cyc; logic [31:0] bid; logic [1:0] win; logic [1:0] er; logic to; } res_t;
    typedef struct { int cyc; int len; } cs_t;

    op_t  opq[$];
    res_t resq[$];
    cs_t  csq[$];
    int   cmp = 0, mis = 0, cyc = 0, accepts = 0, rounds = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        cmp++;
        if (act !== exp) begin
            mis++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Engine stub: err answers the previous cycle's op; roundOver fires ro_delay cycles after C_start falls.
    logic [3:0]  err_op = 4'd0;
    logic [1:0]  err_val = 2'b00;
    int          ro_delay = 1000;
    bit          ro_in_run = 1'b0;
    logic [31:0] eng_bid = 32'd0;
    logic [2:0]  eng_w = 3'b000;
    logic [3:0]  prev_op = 4'd0;
    logic        prev_cs = 1'b0;
    int          since = -1;
    bit          junk;

    always @(negedge clk) begin
        err = (err_op != 4'd0 && prev_op == err_op) ? err_val : 2'b00;
        prev_op = C_op;
        if (prev_cs && !C_start) since = 0;
        else if (since >= 0 && since < 100) since++;
        else since = -1;
        prev_cs = C_start;
        junk = ro_in_run && C_start;
        roundOver = junk || (since == ro_delay);
        maxBid = junk ? 32'd999 : (roundOver ? eng_bid : 32'd0);
        {X_win, Y_win, Z_win} = junk ? 3'b100 : (roundOver ? eng_w : 3'b000);
    end

    // Command / C_start monitor
    logic cs_prev = 1'b0;
    int   cs_len = 0, cs_exp_len = -1;
    always @(negedge clk) begin
        if (!reset_n) begin
            cs_prev = 1'b0;
            cs_len = 0;
        end else begin
            if (C_op != 4'd0) begin
                if (opq.size() == 0) begin
                    cmp++; mis++;
                    $display("FAIL op_unexpected: got op %0d data %0h at cycle %0d, none required", C_op, C_data, cyc);
                end else begin
                    op_t e;
                    e = opq.pop_front();
                    chk("op_cycle_code_data", {cyc, C_op, C_data}, {e.cyc, e.op, e.data});
                end
            end
            if (C_start) begin
                chk("op_zero_while_start", C_op, 0);
                if (!cs_prev) begin
                    if (csq.size() == 0) begin
                        cmp++; mis++; cs_exp_len = -1;
                        $display("FAIL start_unexpected: got C_start=1 at cycle %0d, required 0", cyc);
                    end else begin
                        cs_t c;
                        c = csq.pop_front();
                        chk("start_cycle", cyc, c.cyc);
                        cs_exp_len = c.len;
                    end
                end
                cs_len++;
            end else if (cs_prev) begin
                if (cs_exp_len >= 0) chk("start_len", cs_len, cs_exp_len);
                cs_len = 0;
            end
            cs_prev = C_start;
        end
    end

    // Result monitor
    always @(negedge clk) begin
        if (reset_n && res_valid) begin
            if (resq.size() == 0) begin
                cmp++; mis++;
                $display("FAIL res_unexpected: got bid %0h win %0d err %0d to %0b at cycle %0d", res_maxBid, res_winner, res_err, res_timeout, cyc);
            end else begin
                res_t e;
                e = resq.pop_front();
                chk("result_cycle_bid_win_err_to", {cyc, res_maxBid, res_winner, res_err, res_timeout},
                    {e.cyc, e.bid, e.win, e.er, e.to});
            end
        end
        if (reset_n && cfg_valid && cfg_ready) accepts++;
    end

    task automatic issue_round(input logic [31:0] xv, input logic [31:0] yv, input logic [31:0] zv,
                               input logic [2:0] m, input logic [31:0] tm, input logic [31:0] co,
                               input logic [15:0] len, input bit keep, input int rdyk,
                               input logic [1:0] exp_win);
        logic [3:0]  ops[8];
        logic [31:0] dat[8];
        int n, h, hb, ei, l;
        res_t r;
        ops = '{4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd2};
        dat = '{UNLOCK_KEY, xv, yv, zv, {29'd0, m}, tm, co, UNLOCK_KEY};
        rounds++;
        ready = (rdyk == 0);
        cfg_xval = xv; cfg_yval = yv; cfg_zval = zv; cfg_mask = m;
        cfg_timer = tm; cfg_cost = co; cfg_round_len = len; cfg_valid = 1'b1;
        n = 0;
        while (!cfg_ready && n < 100) begin @(negedge clk); n++; end
        if (!cfg_ready) begin
            cmp++; mis++;
            $display("FAIL handshake: got cfg_ready=0 for 100 cycles, required 1");
            return;
        end
        h = cyc + 1;
        hb = h + rdyk;
        ei = -1;
        for (int i = 0; i < 8; i++)
            if (ei < 0 && err_op != 4'd0 && err_val != 2'b00 && ops[i] == err_op && !(i == 0 && err_val == 2'b10))
                ei = i;
        l = (len == 16'd0) ? 1 : int'(len);
        for (int i = 0; i < 8; i++)
            if (ei < 0 || i <= ei + 1) opq.push_back('{hb + 1 + i, ops[i], dat[i]});
        if (ei >= 0) r = '{hb + 3 + ei, 32'd0, 2'd0, err_val, 1'b0};
        else if (ro_delay < DMAX) r = '{hb + 11 + l + ro_delay, eng_bid, exp_win, 2'd0, 1'b0};
        else r = '{hb + 10 + l + DMAX, 32'd0, 2'd0, 2'd0, 1'b1};
        resq.push_back(r);
        if (ei < 0) csq.push_back('{hb + 10, l});
        @(posedge clk);
        #1;
        if (!keep) cfg_valid = 1'b0;
        cfg_xval = 32'hDEAD_0001; cfg_yval = 32'hDEAD_0002; cfg_zval = 32'hDEAD_0003;
        cfg_mask = 3'b000; cfg_timer = 32'hDEAD_0004; cfg_cost = 32'hDEAD_0005; cfg_round_len = 16'hFFFF;
        @(negedge clk);
        repeat (rdyk) @(negedge clk);
        ready = 1'b1;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((resq.size() != 0 || opq.size() != 0 || csq.size() != 0) && n < 300) begin
            @(negedge clk); n++;
        end
        if (n >= 300) begin
            cmp++; mis++;
            $display("FAIL round_timeout: got %0d results still pending after 300 cycles, required 0", resq.size());
            opq.delete(); resq.delete(); csq.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test by 200000 time units, required end");
        $fatal(1);
    end

    initial begin
        int n;
        cfg_valid = 1'b0; cfg_xval = 0; cfg_yval = 0; cfg_zval = 0; cfg_mask = 0;
        cfg_timer = 0; cfg_cost = 0; cfg_round_len = 0; ready = 1'b1;
        err = 2'b00; roundOver = 1'b0; maxBid = 0; X_win = 0; Y_win = 0; Z_win = 0;
        repeat (2) @(negedge clk);
        chk("rst_C_op", C_op, 0);
        chk("rst_C_data", C_data, 0);
        chk("rst_C_start", C_start, 0);
        chk("rst_cfg_ready", cfg_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_fields", {res_maxBid, res_winner, res_err, res_timeout}, 0);
        reset_n = 1'b1;
        chk("cfg_ready_at_release", cfg_ready, 0);
        @(negedge clk);
        chk("cfg_ready_after_release", cfg_ready, 1);

        // Nominal round, Y wins with 42
        ro_delay = 2; eng_bid = 32'd42; eng_w = 3'b010;
        issue_round(32'd100, 32'd200, 32'd300, 3'b111, 32'd50, 32'd1, 16'd5, 1'b0, 0, 2'd2);
        wait_done();

        // Unlock answered "already unlocked", late ready, junk roundOver during RUN, all flags set
        err_op = 4'd1; err_val = 2'b10; ro_in_run = 1'b1; ro_delay = 0; eng_bid = 32'd77; eng_w = 3'b111;
        issue_round(32'h0000_000A, 32'h0000_000B, 32'h0000_000C, 3'b101, 32'd9, 32'd3, 16'd3, 1'b0, 3, 2'd1);
        wait_done();
        err_op = 4'd0; err_val = 2'b00; ro_in_run = 1'b0;

        // Config error answered after LoadY
        err_op = 4'd4; err_val = 2'b11; ro_delay = 1;
        issue_round(32'd1, 32'd2, 32'd3, 3'b011, 32'd10, 32'd2, 16'd4, 1'b0, 0, 2'd0);
        wait_done();
        err_op = 4'd0; err_val = 2'b00;
        repeat (3) @(negedge clk);
        chk("res_err_held", {res_valid, res_err}, {1'b0, 2'b11});

        // Timeout: roundOver never arrives
        ro_delay = 1000;
        issue_round(32'd5, 32'd6, 32'd7, 3'b110, 32'd20, 32'd4, 16'd2, 1'b0, 0, 2'd0);
        chk("res_err_cleared", res_err, 0);
        wait_done();
        chk("res_timeout_held", res_timeout, 1);

        // Z-only winner on the last drain cycle
        ro_delay = 7; eng_bid = 32'hFFFF_FFFF; eng_w = 3'b001;
        issue_round(32'd8, 32'd9, 32'd10, 3'b001, 32'd30, 32'd5, 16'd1, 1'b0, 0, 2'd3);
        chk("res_timeout_cleared", res_timeout, 0);
        wait_done();

        // Reset pulsed during MASK
        ro_delay = 1; eng_bid = 32'd11; eng_w = 3'b100;
        issue_round(32'd21, 32'd22, 32'd23, 3'b010, 32'd24, 32'd25, 16'd3, 1'b0, 0, 2'd1);
        n = 0;
        while (C_op != 4'd6 && n < 20) begin @(negedge clk); n++; end
        chk("reached_mask", C_op, 6);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_C_op_data_start", {C_op, C_data, C_start}, 0);
        chk("midrst_cfg_ready", cfg_ready, 0);
        opq.delete(); resq.delete(); csq.delete();
        @(negedge clk);
        reset_n = 1'b1;
        chk("midrst_cfg_ready_at_release", cfg_ready, 0);
        @(negedge clk);
        chk("midrst_cfg_ready_after_release", cfg_ready, 1);

        // Zero round length with cfg_valid held high into a second request
        ro_delay = 1; eng_bid = 32'd64; eng_w = 3'b100;
        issue_round(32'd31, 32'd32, 32'd33, 3'b111, 32'd34, 32'd35, 16'd0, 1'b1, 0, 2'd1);
        wait_done();
        ro_delay = 3; eng_bid = 32'd5; eng_w = 3'b000;
        issue_round(32'd41, 32'd42, 32'd43, 3'b100, 32'd44, 32'd45, 16'd1, 1'b0, 0, 2'd0);
        wait_done();
        repeat (4) @(negedge clk);

        chk("accept_count", accepts, rounds);
        chk("queues_empty", opq.size() + resq.size() + csq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
        $finish;
    end

endmodule
